// File: rtl/ravenoc_pkg.sv
// Shared RaveNoC types and constants for the router input path.
package ravenoc_pkg;

    localparam int N_VIRT_CHN = 3;
    localparam int FLIT_WIDTH = 8;
    localparam int BUFF_DEPTH = 4;
    localparam int VC_WIDTH   = (N_VIRT_CHN > 1) ? $clog2(N_VIRT_CHN) : 1;

    typedef struct packed {
        logic                  valid;
        logic [FLIT_WIDTH-1:0] fdata;
        logic [VC_WIDTH-1:0]   vc_id;
    } s_flit_req_t;

    typedef struct packed {
        logic [N_VIRT_CHN-1:0] ready;
    } s_flit_resp_t;

endpackage

// File: rtl/vc_fifo.sv
// Single virtual-channel flit FIFO. Wrap-bit pointers distinguish full from
// empty. Storage is deliberately left unreset; only the pointers are cleared.
module vc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             write_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             read_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]               wr_ptr, rd_ptr;
    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic                        do_wr, do_rd;

    assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty_o = (wr_ptr == rd_ptr);
    assign data_o  = mem[rd_ptr[AW-1:0]];

    // Guard locally as well so a misbehaving caller cannot corrupt occupancy.
    assign do_wr = write_i && !full_o;
    assign do_rd = read_i && !empty_o;

    // Pointer advance; both may move in the same cycle.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PW'(1);
            if (do_rd) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Flit storage write.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/vc_input_buffer.sv
// Per-port input buffer: one FIFO per VC, fixed-priority (highest VC wins)
// presentation to the input router. Outputs depend only on registered state.
module vc_input_buffer
    import ravenoc_pkg::*;
#(
    parameter int BUFF_DEPTH = ravenoc_pkg::BUFF_DEPTH
) (
    input  logic                  clk,
    input  logic                  arst,
    input  s_flit_req_t           fin_req_i,
    output s_flit_resp_t          fin_resp_o,
    output s_flit_req_t           fout_req_o,
    input  s_flit_resp_t          fout_resp_i,
    output logic [N_VIRT_CHN-1:0] vc_empty_o
);

    logic [N_VIRT_CHN-1:0]                 wr_en, rd_en, full, empty;
    logic [N_VIRT_CHN-1:0][FLIT_WIDTH-1:0] head;
    logic [VC_WIDTH-1:0]                   sel;
    logic                                  any_vld;

    for (genvar v = 0; v < N_VIRT_CHN; v++) begin : g_vc
        // Out-of-range vc_id matches no lane and is dropped.
        assign wr_en[v] = fin_req_i.valid && (fin_req_i.vc_id == VC_WIDTH'(v)) && !full[v];
        assign rd_en[v] = any_vld && (sel == VC_WIDTH'(v)) && fout_resp_i.ready[v];

        vc_fifo #(
            .WIDTH (FLIT_WIDTH),
            .DEPTH (BUFF_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .arst    (arst),
            .write_i (wr_en[v]),
            .data_i  (fin_req_i.fdata),
            .read_i  (rd_en[v]),
            .data_o  (head[v]),
            .full_o  (full[v]),
            .empty_o (empty[v])
        );
    end

    assign fin_resp_o.ready = ~full;
    assign vc_empty_o       = empty;

    // Fixed-priority select: last non-empty VC in ascending scan wins.
    always_comb begin
        sel     = '0;
        any_vld = 1'b0;
        for (int v = 0; v < N_VIRT_CHN; v++) begin
            if (!empty[v]) begin
                sel     = VC_WIDTH'(v);
                any_vld = 1'b1;
            end
        end
    end

    // Present the selected head; all-zero when nothing is buffered.
    always_comb begin
        fout_req_o = '0;
        if (any_vld) begin
            fout_req_o.valid = 1'b1;
            fout_req_o.fdata = head[sel];
            fout_req_o.vc_id = sel;
        end
    end

endmodule

// File: tb/tb_vc_input_buffer.sv
// Directed bench for vc_input_buffer with a dequeue scoreboard.
module tb_vc_input_buffer;
    import ravenoc_pkg::*;

    logic                  clk;
    logic                  arst;
    s_flit_req_t           fin_req;
    s_flit_resp_t          fin_resp;
    s_flit_req_t           fout_req;
    s_flit_resp_t          fout_resp;
    logic [N_VIRT_CHN-1:0] vc_empty;

    int n_pass  = 0;
    int n_total = 0;
    logic [VC_WIDTH+FLIT_WIDTH-1:0] exp_q[$];

    vc_input_buffer #(.BUFF_DEPTH(2)) dut (
        .clk         (clk),
        .arst        (arst),
        .fin_req_i   (fin_req),
        .fin_resp_o  (fin_resp),
        .fout_req_o  (fout_req),
        .fout_resp_i (fout_resp),
        .vc_empty_o  (vc_empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d, input logic [1:0] vc);
        fin_req.valid = 1'b1;
        fin_req.fdata = d;
        fin_req.vc_id = vc;
    endtask

    task automatic idle();
        fin_req = '0;
    endtask

    task automatic push(input logic [1:0] vc, input logic [7:0] d);
        exp_q.push_back({vc, d});
    endtask

    // Monitor: a handshake at the sampling point means this flit leaves at the next edge.
    always @(negedge clk) begin
        if (!arst && fout_req.valid && fout_resp.ready[fout_req.vc_id]) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL sb_unexpected got=%0h", {fout_req.vc_id, fout_req.fdata});
            end else begin
                chk("sb_flit", {fout_req.vc_id, fout_req.fdata}, exp_q.pop_front());
            end
        end
    end

    initial begin
        arst      = 1'b1;
        fin_req   = '0;
        fout_resp = '0;
        cyc();
        cyc();
        chk("rst_ready", fin_resp.ready, 3'b111);
        chk("rst_valid", fout_req.valid, 0);
        chk("rst_empty", vc_empty, 3'b111);
        arst = 1'b0;
        cyc();

        // Reset mid-packet discards buffered flits, asynchronously.
        wr(8'h55, 0);
        cyc();
        idle();
        chk("pre_rst_empty", vc_empty, 3'b110);
        chk("pre_rst_valid", fout_req.valid, 1);
        #2 arst = 1'b1;
        #1;
        chk("arst_ready", fin_resp.ready, 3'b111);
        chk("arst_fout", fout_req, 0);
        chk("arst_empty", vc_empty, 3'b111);
        cyc();
        arst = 1'b0;
        cyc();

        // Single flit with one-cycle latency.
        fout_resp.ready = 3'b111;
        wr(8'hA5, 1);
        push(1, 8'hA5);
        cyc();
        idle();
        chk("single_valid", fout_req.valid, 1);
        chk("single_vc", fout_req.vc_id, 1);
        chk("single_data", fout_req.fdata, 8'hA5);
        cyc();
        chk("single_drained", fout_req.valid, 0);

        // Full and back-pressure on VC0.
        fout_resp.ready = 3'b000;
        wr(8'h01, 0);
        cyc();
        wr(8'h02, 0);
        chk("half_ready0", fin_resp.ready[0], 1);
        cyc();
        chk("full_ready0", fin_resp.ready[0], 0);
        wr(8'h03, 0);
        cyc();
        idle();
        chk("full_hold_ready0", fin_resp.ready[0], 0);
        chk("full_head", fout_req.fdata, 8'h01);
        push(0, 8'h01);
        push(0, 8'h02);
        fout_resp.ready = 3'b111;
        cyc();
        chk("freed_ready0", fin_resp.ready[0], 1);
        chk("second_head", fout_req.fdata, 8'h02);
        cyc();
        chk("bp_drained", vc_empty, 3'b111);

        // Preemption by VC2 while VC0 is presenting.
        fout_resp.ready = 3'b000;
        wr(8'h10, 0);
        cyc();
        wr(8'h11, 0);
        cyc();
        idle();
        chk("pre_head", fout_req.fdata, 8'h10);
        wr(8'h20, 2);
        cyc();
        idle();
        chk("preempt_vc", fout_req.vc_id, 2);
        chk("preempt_data", fout_req.fdata, 8'h20);
        push(2, 8'h20);
        push(0, 8'h10);
        push(0, 8'h11);
        fout_resp.ready = 3'b111;
        cyc();
        chk("resume_vc", fout_req.vc_id, 0);
        chk("resume_data", fout_req.fdata, 8'h10);
        cyc();
        chk("resume_data2", fout_req.fdata, 8'h11);
        cyc();
        chk("preempt_drained", fout_req.valid, 0);

        // Concurrent read and write on VC1.
        fout_resp.ready = 3'b000;
        wr(8'h30, 1);
        cyc();
        idle();
        chk("conc_ready1_pre", fin_resp.ready[1], 1);
        wr(8'h33, 1);
        fout_resp.ready = 3'b010;
        push(1, 8'h30);
        push(1, 8'h33);
        cyc();
        idle();
        fout_resp.ready = 3'b000;
        chk("conc_empty1", vc_empty[1], 0);
        chk("conc_data", fout_req.fdata, 8'h33);
        chk("conc_ready1", fin_resp.ready[1], 1);
        wr(8'h34, 1);
        push(1, 8'h34);
        cyc();
        idle();
        chk("conc_occ_full", fin_resp.ready[1], 0);
        fout_resp.ready = 3'b111;
        cyc();
        cyc();
        chk("conc_drained", vc_empty, 3'b111);

        // Out-of-range VC is dropped.
        fout_resp.ready = 3'b000;
        wr(8'h77, 3);
        cyc();
        idle();
        cyc();
        chk("inv_empty", vc_empty, 3'b111);
        chk("inv_valid", fout_req.valid, 0);
        chk("inv_ready", fin_resp.ready, 3'b111);

        cyc();
        chk("sb_leftover", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
